prog_clk_div: RTL

//   Multi-channel programmable clock divider. Successor to the fixed power-of-two divider.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_ch.sv | 69 ++++++
 rtl/prog_clk_div.sv | 100 ++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  // Smallest divisor that still yields a distinct high and low phase.
  localparam int MIN_DIV = 2;

  // Number of high cycles at the start of a period of length d.
  function automatic int unsigned hi_len(input int unsigned d);
    return d >> 1;
  endfunction

  // Width of a channel-select field; a single channel still gets one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, active divisor, registered CLK_OUT/TICK.
// The phase counter value at a clock edge selects the outputs shown in the
// following cycle, so phase 0 appears as TICK=1 one cycle after it is sampled.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RST_DIV = 2048
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             apply_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             terminal_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             terminal;

  // Last phase of the current period; a new divisor may only land here.
  assign terminal   = (cnt_q == (div_q - CNT_W'(1)));
  assign terminal_o = terminal;
  assign clk_out_o  = clk_out_q;
  assign tick_o     = tick_q;

  // Next-state: disable parks the counter at phase 0, otherwise count and wrap.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;
    // The top only strobes apply at a terminal phase or while disabled,
    // so the counter never sits beyond the new divisor's range.
    if (apply_i) begin
      div_d = div_i;
    end
    if (!en_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end else begin
      tick_d    = (cnt_q == '0);
      clk_out_d = (32'(cnt_q) < hi_len(32'(div_q)));
      cnt_d     = terminal ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  // State registers with synchronous reset to the power-on divisor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(RST_DIV);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider. A single pending slot buffers one
// divisor write; it is handed to its channel at that channel's period
// boundary (or immediately while the channel is disabled), so the running
// period always completes with the old divisor.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int NUM_CH  = 2,
  parameter int RST_DIV = 2048,
  // Derived from NUM_CH; leave at its default.
  parameter int SEL_W   = sel_width(NUM_CH)
) (
  input  logic              CLK_100MHz,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic [CNT_W-1:0]  DIV_IN,
  input  logic [SEL_W-1:0]  DIV_SEL,
  input  logic              DIV_VALID,
  output logic              DIV_READY,
  output logic              DIV_ERR,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK
);

  logic              pend_vld_q, pend_vld_d;
  logic [SEL_W-1:0]  pend_sel_q, pend_sel_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] terminal;
  logic [NUM_CH-1:0] apply;
  logic              wr_fire;
  logic              wr_illegal;

  // The slot is the only back-pressure source: ready whenever it is empty.
  assign DIV_READY  = !pend_vld_q;
  assign DIV_ERR    = err_q;
  assign wr_fire    = DIV_VALID && !pend_vld_q;
  assign wr_illegal = (32'(DIV_IN) < 32'(MIN_DIV)) || (32'(DIV_SEL) >= 32'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Deliver the pending divisor at the target's boundary, or at once if it is idle.
      assign apply[gi] = pend_vld_q && (pend_sel_q == SEL_W'(gi)) &&
                         (!EN[gi] || terminal[gi]);

      clk_div_ch #(
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV)
      ) u_ch (
        .clk_i      (CLK_100MHz),
        .rst_i      (RST),
        .en_i       (EN[gi]),
        .apply_i    (apply[gi]),
        .div_i      (pend_div_q),
        .clk_out_o  (CLK_OUT[gi]),
        .tick_o     (TICK[gi]),
        .terminal_o (terminal[gi])
      );
    end
  endgenerate

  // Slot bookkeeping: drain on apply, fill on a legal write, flag illegal ones.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
    pend_div_d = pend_div_q;
    err_d      = 1'b0;
    if (|apply) begin
      pend_vld_d = 1'b0;
    end
    // A write can only fire while the slot is empty, so it never races an apply.
    if (wr_fire) begin
      if (wr_illegal) begin
        err_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_sel_d = DIV_SEL;
        pend_div_d = DIV_IN;
      end
    end
  end

  // Slot and error registers; reset discards any pending write.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      pend_vld_q <= 1'b0;
      pend_sel_q <= '0;
      pend_div_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
      pend_div_q <= pend_div_d;
      err_q      <= err_d;
    end
  end

endmodule
